// File: rtl/mem_port_arbiter.sv
// Two-master (CPU, DMA) arbiter for one single-ported memory.
// Define ARB_RR_EN for round-robin contention; default is fixed CPU priority.
module mem_port_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_done,
  input  logic        dma_req,
  input  logic        dma_wr,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_done,
  output logic [15:0] rdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  localparam logic [3:0] WAITV = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        own_dma_q, own_dma_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        cpu_win;

`ifdef ARB_RR_EN
  logic last_dma_q, last_dma_d;

  // CPU wins unless DMA also asks and CPU was the last winner
  always_comb begin
    cpu_win = cpu_req & (~dma_req | last_dma_q);
  end
`else
  always_comb begin
    cpu_win = cpu_req;
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    own_dma_d = own_dma_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
`ifdef ARB_RR_EN
    last_dma_d = last_dma_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cpu_req | dma_req) begin
          state_d   = ACCESS;
          cnt_d     = WAITV;
          own_dma_d = ~cpu_win;
          wr_d      = cpu_win ? cpu_wr : dma_wr;
          addr_d    = cpu_win ? cpu_addr : dma_addr;
          wdata_d   = cpu_win ? cpu_wdata : dma_wdata;
`ifdef ARB_RR_EN
          last_dma_d = ~cpu_win;
`endif
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (!wr_q) rdata_d = mem_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      own_dma_q <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= 16'h0000;
      wdata_q   <= 16'h0000;
      rdata_q   <= 16'h0000;
`ifdef ARB_RR_EN
      last_dma_q <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      own_dma_q <= own_dma_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
`ifdef ARB_RR_EN
      last_dma_q <= last_dma_d;
`endif
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    cpu_gnt   = busy & ~own_dma_q;
    dma_gnt   = busy & own_dma_q;
    cpu_done  = (state_q == DONE) & ~own_dma_q;
    dma_done  = (state_q == DONE) & own_dma_q;
    mem_rd    = (state_q == ACCESS) & ~wr_q;
    mem_wr    = (state_q == ACCESS) & wr_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    rdata     = rdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (WAIT_CYCLES 1, 0 and 15).
// Contention expectations follow ARB_RR_EN.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_wr, dma_req, dma_wr;
  logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [15:0] mem_rdata;

  logic [2:0]  cg, cd, dg, dd, bz, mrd, mwr;
  logic [15:0] rd [3];
  logic [15:0] ma [3];
  logic [15:0] mwd [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cg[0]), .cpu_done(cd[0]),
    .dma_req(dma_req), .dma_wr(dma_wr),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dg[0]), .dma_done(dd[0]),
    .rdata(rd[0]), .mem_rd(mrd[0]), .mem_wr(mwr[0]),
    .mem_addr(ma[0]), .mem_wdata(mwd[0]),
    .mem_rdata(mem_rdata), .busy(bz[0])
  );

  mem_port_arbiter #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cg[1]), .cpu_done(cd[1]),
    .dma_req(dma_req), .dma_wr(dma_wr),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dg[1]), .dma_done(dd[1]),
    .rdata(rd[1]), .mem_rd(mrd[1]), .mem_wr(mwr[1]),
    .mem_addr(ma[1]), .mem_wdata(mwd[1]),
    .mem_rdata(mem_rdata), .busy(bz[1])
  );

  mem_port_arbiter #(.WAIT_CYCLES(15)) dut15 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cg[2]), .cpu_done(cd[2]),
    .dma_req(dma_req), .dma_wr(dma_wr),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dg[2]), .dma_done(dd[2]),
    .rdata(rd[2]), .mem_rd(mrd[2]), .mem_wr(mwr[2]),
    .mem_addr(ma[2]), .mem_wdata(mwd[2]),
    .mem_rdata(mem_rdata), .busy(bz[2])
  );

  typedef struct {
    bit          dma;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] mrd;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_wr = 0;
    cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_wr = 0;
    dma_addr = 0; dma_wdata = 0;
    mem_rdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 0;
    @(negedge clk);
    reset = 1;
  endtask

  task automatic do_access(input vec_t v, input int idx);
    int ok = 0, bad = 0, own = 0, oth = 0, both = 0;
    int abad = 0, gbad = 0;
    logic [15:0] rdv = 16'hxxxx;
    @(negedge clk);
    mem_rdata = v.mrd;
    if (v.dma) begin
      dma_req = 1; dma_wr = v.wr;
      dma_addr = v.addr; dma_wdata = v.wdata;
    end else begin
      cpu_req = 1; cpu_wr = v.wr;
      cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        cpu_req = 0;
        dma_req = 0;
      end
      if (cg[0] && dg[0]) both++;
      if ((v.dma ? cg[0] : dg[0]) === 1'b1) gbad++;
      if (v.wr ? mwr[0] : mrd[0]) begin
        ok++;
        if (ma[0] !== v.addr || mwd[0] !== v.wdata)
          abad++;
      end
      if (v.wr ? mrd[0] : mwr[0]) bad++;
      if (v.dma ? dd[0] : cd[0]) begin
        own++;
        rdv = rd[0];
      end
      if (v.dma ? cd[0] : dd[0]) oth++;
    end
    chk($sformatf("v%0d strobes", idx), ok, 2);
    chk($sformatf("v%0d wrong_strobe", idx), bad, 0);
    chk($sformatf("v%0d addr_wdata", idx), abad, 0);
    chk($sformatf("v%0d done_own", idx), own, 1);
    chk($sformatf("v%0d done_other", idx), oth, 0);
    chk($sformatf("v%0d gnt", idx), both + gbad, 0);
    chk($sformatf("v%0d rdata", idx), rdv, v.exp_rdata);
  endtask

  // Transaction-level reference: age counts cycles since grant.
  localparam int W = 1;
  int          m_age;
  bit          m_dma, m_wr, m_last_dma;
  logic [15:0] m_addr, m_wd, m_rd;

  task automatic model_reset();
    m_age = 0; m_dma = 0; m_wr = 0;
    m_last_dma = 1;
    m_addr = 0; m_wd = 0; m_rd = 0;
  endtask

  function automatic logic [54:0] model_out();
    bit b, acc, dn;
    b   = (m_age != 0);
    acc = (m_age >= 1) && (m_age <= W + 1);
    dn  = (m_age == W + 2);
    return {b & ~m_dma, dn & ~m_dma,
            b & m_dma, dn & m_dma, b,
            acc & ~m_wr, acc & m_wr,
            m_rd, m_addr, m_wd};
  endfunction

  task automatic model_step();
    bit cw;
    if (!reset) begin
      model_reset();
    end else if (m_age == 0) begin
      if (cpu_req || dma_req) begin
`ifdef ARB_RR_EN
        cw = cpu_req && (!dma_req || m_last_dma);
`else
        cw = cpu_req;
`endif
        m_dma = !cw;
        m_last_dma = !cw;
        m_wr = cw ? cpu_wr : dma_wr;
        m_addr = cw ? cpu_addr : dma_addr;
        m_wd = cw ? cpu_wdata : dma_wdata;
        m_age = 1;
      end
    end else begin
      if (m_age == W + 1 && !m_wr) m_rd = mem_rdata;
      m_age = (m_age == W + 2) ? 0 : m_age + 1;
    end
  endtask

  initial begin
    int win [$];
    int cnt [3];
    int first [3];
    int dcyc [3];
    int nd;
    logic [54:0] act;

    tbl[0] = '{0, 0, 16'h0040, 16'h1111, 16'hBEEF, 16'hBEEF};
    tbl[1] = '{1, 1, 16'h00FF, 16'h1234, 16'h5555, 16'hBEEF};
    tbl[2] = '{0, 1, 16'hFFFF, 16'hA5A5, 16'h7777, 16'hBEEF};
    tbl[3] = '{1, 0, 16'h0000, 16'h0000, 16'h0001, 16'h0001};
    tbl[4] = '{0, 0, 16'h8000, 16'hFFFF, 16'hFFFF, 16'hFFFF};

    reset = 0;
    idle_inputs();
    do_reset();
    @(negedge clk);
    chk("reset_state",
        {cg[0], cd[0], dg[0], dd[0], bz[0], mrd[0], mwr[0],
         rd[0], ma[0], mwd[0]}, 55'd0);
    chk("reset_busy_w0_w15", {bz[1], bz[2]}, 2'b00);

    for (int i = 0; i < 5; i++) do_access(tbl[i], i);

    // Both masters hold a read request for four accesses.
    do_reset();
    @(negedge clk);
    cpu_req = 1; dma_req = 1;
    cpu_wr = 0; dma_wr = 0;
    mem_rdata = 16'h3C3C;
    for (int k = 0; k < 40 && win.size() < 4; k++) begin
      @(negedge clk);
      if (cd[0]) win.push_back(0);
      if (dd[0]) win.push_back(1);
    end
    cpu_req = 0; dma_req = 0;
    chk("contend_count", win.size(), 4);
    for (int i = 0; i < 4; i++) begin
      int e;
`ifdef ARB_RR_EN
      e = i % 2;
`else
      e = 0;
`endif
      chk($sformatf("contend_win%0d", i),
          (i < win.size()) ? win[i] : -1, e);
    end
    @(negedge clk);
    chk("contend_rdata", rd[0], 16'h3C3C);

    // Reset during the second ACCESS cycle of a read.
    cpu_req = 1; cpu_wr = 0; cpu_addr = 16'h0040;
    @(negedge clk);
    cpu_req = 0;
    chk("rst_mid_acc1", mrd[0], 1'b1);
    @(negedge clk);
    chk("rst_mid_acc2", mrd[0], 1'b1);
    reset = 0;
    @(negedge clk);
    reset = 1;
    chk("rst_mid_after",
        {bz[0], mrd[0], mwr[0], cg[0], cd[0], rd[0], ma[0]},
        21'd0);
    nd = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      nd += int'(cd[0]) + int'(dd[0]);
    end
    chk("rst_mid_no_done", nd, 0);

    // Latency for WAIT_CYCLES 1, 0 and 15.
    do_reset();
    @(negedge clk);
    cpu_req = 1; cpu_wr = 0; cpu_addr = 16'h0100;
    mem_rdata = 16'h4242;
    for (int d = 0; d < 3; d++) begin
      cnt[d] = 0; first[d] = -1; dcyc[d] = -1;
    end
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 1) cpu_req = 0;
      for (int d = 0; d < 3; d++) begin
        if (mrd[d]) begin
          cnt[d]++;
          if (first[d] < 0) first[d] = k;
        end
        if (cd[d] && dcyc[d] < 0) dcyc[d] = k;
      end
    end
    chk("lat_w1_strobes", cnt[0], 2);
    chk("lat_w1_done", dcyc[0], 3);
    chk("lat_w0_strobes", cnt[1], 1);
    chk("lat_w0_first", first[1], 1);
    chk("lat_w0_done", dcyc[1], 2);
    chk("lat_w15_strobes", cnt[2], 16);
    chk("lat_w15_first", first[2], 1);
    chk("lat_w15_done", dcyc[2], 17);
    chk("lat_w15_rdata", rd[2], 16'h4242);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      act = {cg[0], cd[0], dg[0], dd[0], bz[0], mrd[0], mwr[0],
             rd[0], ma[0], mwd[0]};
      chk($sformatf("rand%0d", n), act, model_out());
      reset = ($urandom_range(0, 39) != 0);
      cpu_req = ($urandom_range(0, 9) < 4);
      dma_req = ($urandom_range(0, 9) < 4);
      cpu_wr = $urandom_range(0, 1) != 0;
      dma_wr = $urandom_range(0, 1) != 0;
      cpu_addr = 16'($urandom);
      cpu_wdata = 16'($urandom);
      dma_addr = 16'($urandom);
      dma_wdata = 16'($urandom);
      mem_rdata = 16'($urandom);
      model_step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, extra cycles mem_rd/mem_wr are held beyond the first; legal range 0-15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 cpu_req  input  1  CPU sequencer access request, level.
REQ-005 cpu_wr  input  1  CPU access type (1 write, 0 read).
REQ-006 cpu_addr  input  16  CPU word address.
REQ-007 cpu_wdata  input  16  CPU write data.
REQ-008 cpu_gnt  output  1  CPU owns the memory port.
REQ-009 cpu_done  output  1  one-cycle CPU completion pulse.
REQ-010 dma_req  input  1  DMA/debug master access request, level.
REQ-011 dma_wr  input  1  DMA access type.
REQ-012 dma_addr  input  16  DMA word address.
REQ-013 dma_wdata  input  16  DMA write data.
REQ-014 dma_gnt  output  1  DMA owns the memory port.
REQ-015 dma_done  output  1  one-cycle DMA completion pulse.
REQ-016 rdata  output  16  registered read data, shared by both masters.
REQ-017 mem_rd, mem_wr  output  1 each  memory strobes, never both high.
REQ-018 mem_addr, mem_wdata  output  16 each  registered memory address and write data.
REQ-019 mem_rdata  input  16  memory read data, valid in last strobe cycle.
REQ-020 busy  output  1  high whenever state is not IDLE.

Function
REQ-021 States: IDLE, ACCESS, DONE; IDLE->ACCESS when any req high, ACCESS->DONE after WAIT_CYCLES+1 cycles, DONE->IDLE unconditionally.
REQ-022 Requests are sampled only in IDLE; req, wr, addr, wdata from the winner are latched on the IDLE->ACCESS edge; loser's request stays pending, never dropped.
REQ-023 Winner's gnt is high from the first ACCESS cycle through DONE inclusive; at most one gnt high at any time.
REQ-024 In ACCESS exactly one of mem_rd/mem_wr (per latched wr) is high every cycle; mem_addr/mem_wdata stable throughout.
REQ-025 Wait counter is 4 bits, loads WAIT_CYCLES on entry to ACCESS, decrements each ACCESS cycle, exit when zero; no wrap.
REQ-026 On reads, rdata <= mem_rdata on the final ACCESS edge; rdata holds until the next read completes; writes never change rdata.
REQ-027 done pulses for the winner during DONE only, with rdata valid that cycle.
REQ-028 Latency: req sampled cycle 0 -> strobes cycles 1..WAIT_CYCLES+1 -> done cycle WAIT_CYCLES+2; minimum one IDLE cycle between accesses.
REQ-029 req still high in the IDLE after done is a new access; masters drop req in the done cycle to avoid repeats.
REQ-030 Requests arriving in ACCESS/DONE wait for IDLE; req deassertion mid-access does not abort it.

Reset
REQ-031 reset low at any clock edge, including mid-ACCESS: state IDLE, counter 0, all gnt/done/strobes 0, mem_addr/mem_wdata/rdata 0x0000, access abandoned with no done.
REQ-032 Reset sets last-winner to DMA, so the first contended grant goes to CPU.

Configuration
REQ-033 ARB_RR_EN defined: on simultaneous requests the master not granted last wins (round-robin); last-winner updates on every grant.
REQ-034 ARB_RR_EN undefined: fixed priority, CPU always wins contention; last-winner register omitted.

Verification
REQ-035 WAIT_CYCLES=1, CPU read 0x0040, mem_rdata=0xBEEF -> mem_rd high cycles 1-2, cpu_done cycle 3, rdata=0xBEEF.
REQ-036 DMA write 0x1234 to 0x00FF -> mem_wr high 2 cycles, mem_addr=0x00FF, mem_wdata=0x1234, dma_done once, rdata unchanged.
REQ-037 Both req held high for 4 accesses, ARB_RR_EN defined -> grants CPU,DMA,CPU,DMA; undefined -> CPU x4, DMA never granted.
REQ-038 reset low in 2nd ACCESS cycle of a read -> next cycle busy=0, strobes 0, rdata=0x0000, no done pulse.
REQ-039 WAIT_CYCLES=0 and WAIT_CYCLES=15 -> strobes exactly 1 and 16 cycles, done at cycle 2 and 17.
